// File: rtl/halflife_pkg.sv
// halflife_pkg: shared state encoding and default widths for the half-life decay controller.
package halflife_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_P = 8;
endpackage

// File: rtl/halflife_prescaler.sv
// halflife_prescaler: reloadable P-bit down-counter that stops at zero and flags it.
module halflife_prescaler import halflife_pkg::*; #(
  parameter int P = DEF_P
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [P-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [P-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= !rst ? '0 : load ? load_val : (en && r_cnt != '0) ? r_cnt - P'(1) : r_cnt;
  assign zero = r_cnt == '0;
endmodule

// File: rtl/halflife_decay_ctrl.sv
// halflife_decay_ctrl: halves a quantity every period cycles until it reaches zero,
// with pause, restart and per-halving tick.
module halflife_decay_ctrl import halflife_pkg::*; #(
  parameter int N = DEF_N,
  parameter int P = DEF_P,
  localparam int HW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic [N-1:0]  init,
  input  logic [P-1:0]  period,
  output logic [N-1:0]  value,
  output logic [HW-1:0] halvings,
  output logic          tick,
  output logic          busy,
  output logic          done
);
  state_t       r_state;
  logic [P-1:0] r_pm1;
  logic [P-1:0] w_pm1_new;
  logic [N-1:0] w_half;
  logic         w_zero, w_run, w_halve;
  // period 0 behaves as 1, so the reload value saturates at 0
  assign w_pm1_new = (period == '0) ? '0 : period - P'(1);
  assign w_half    = value >> 1;
  assign w_run     = r_state == RUN && !hold;
  assign w_halve   = w_run && w_zero;
  halflife_prescaler #(.P(P)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .load     (start || w_halve),
    .load_val (start ? w_pm1_new : r_pm1),
    .en       (w_run),
    .zero     (w_zero)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_pm1    <= '0;
      value    <= '0;
      halvings <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (start) begin
        r_state  <= RUN;
        r_pm1    <= w_pm1_new;
        value    <= init;
        halvings <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else if (w_halve) begin
        value    <= w_half;
        halvings <= halvings + HW'(1);
        tick     <= 1'b1;
        if (w_half == '0) begin
          r_state <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_halflife_decay_ctrl.sv
// tb_halflife_decay_ctrl: vector table, directed corner sequences and random
// stimulus checked against a cycle-counting reference model.
module tb_halflife_decay_ctrl;
  localparam int N  = 4;
  localparam int P  = 8;
  localparam int HW = $clog2(N + 1);
  localparam int OW = N + HW + 3;

  logic          clk = 1'b0;
  logic          rst, start, hold;
  logic [N-1:0]  init;
  logic [P-1:0]  period;
  logic [N-1:0]  value;
  logic [HW-1:0] halvings;
  logic          tick, busy, done;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 running, 2 finished; counts unheld cycles since last start/halving
  int m_state = 0, m_val = 0, m_h = 0, m_pe = 1, m_cnt = 0;
  bit m_tick = 0;

  typedef struct {
    logic         r, s, h;
    logic [N-1:0] in;
    logic [P-1:0] pe;
    int           v, hv;
    logic         t, b, d;
  } vec_t;
  vec_t tbl[16];

  halflife_decay_ctrl #(.N(N), .P(P)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .init(init), .period(period),
    .value(value), .halvings(halvings), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] got();
    return {value, halvings, tick, busy, done};
  endfunction

  function automatic logic [OW-1:0] pack(int v, int hv, logic t, logic b, logic d);
    return {N'(v), HW'(hv), t, b, d};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (value,halvings,tick,busy,done)", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_state = 0; m_val = 0; m_h = 0; m_cnt = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (start) begin
        m_state = 1; m_val = int'(init); m_h = 0; m_cnt = 0;
        m_pe = (period == 0) ? 1 : int'(period);
      end else if (m_state == 1 && !hold) begin
        m_cnt++;
        if (m_cnt == m_pe) begin
          m_val = m_val / 2; m_h++; m_tick = 1; m_cnt = 0;
          if (m_val == 0) m_state = 2;
        end
      end
    end
  endtask

  task automatic cyc(input string name, input logic r, s, h,
                     input logic [N-1:0] in, input logic [P-1:0] pe);
    rst = r; start = s; hold = h; init = in; period = pe;
    @(posedge clk);
    model_step();
    #1;
    check(name, got(), pack(m_val, m_h, m_tick, m_state == 1, m_state == 2));
  endtask

  task automatic run_idle(input string name, input int n);
    for (int i = 0; i < n; i++) cyc(name, 1, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0; init = '0; period = '0;
    // init=12 period=3 run from reset to done, then hold in DONE
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 12, 3, 12, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 7,  12, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0,  12, 0, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0,  6, 1, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0,  6, 1, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0,  6, 1, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0,  3, 2, 1, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 0,  3, 2, 0, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0,  3, 2, 0, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0,  1, 3, 1, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0,  1, 3, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 0,  1, 3, 0, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 0,  0, 4, 1, 0, 1};
    tbl[14] = '{1, 0, 0, 0, 0,  0, 4, 0, 0, 1};
    tbl[15] = '{1, 0, 1, 9, 1,  0, 4, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("table_model[%0d]", i), tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].in, tbl[i].pe);
      check($sformatf("table[%0d]", i), got(), pack(tbl[i].v, tbl[i].hv, tbl[i].t, tbl[i].b, tbl[i].d));
    end

    // period 0 halves every cycle
    cyc("p0_start", 1, 1, 0, 5, 0);
    cyc("p0_e1", 1, 0, 0, 0, 0);
    check("p0_v2", got(), pack(2, 1, 1, 1, 0));
    cyc("p0_e2", 1, 0, 0, 0, 0);
    check("p0_v1", got(), pack(1, 2, 1, 1, 0));
    cyc("p0_e3", 1, 0, 0, 0, 0);
    check("p0_v0", got(), pack(0, 3, 1, 0, 1));

    // hold during edges 2-6 delays first halving to edge 9
    cyc("hold_start", 1, 1, 0, 8, 4);
    cyc("hold_e1", 1, 0, 0, 0, 0);
    for (int e = 2; e <= 6; e++) cyc("hold_frozen", 1, 0, 1, 0, 0);
    check("hold_no_tick", got(), pack(8, 0, 0, 1, 0));
    run_idle("hold_resume", 2);
    check("hold_e8", got(), pack(8, 0, 0, 1, 0));
    cyc("hold_e9", 1, 0, 0, 0, 0);
    check("hold_first_half", got(), pack(4, 1, 1, 1, 0));

    // restart mid-run latches the new init and period
    cyc("rs_start", 1, 1, 0, 15, 5);
    run_idle("rs_run", 6);
    check("rs_e6", got(), pack(7, 1, 0, 1, 0));
    cyc("rs_restart", 1, 1, 1, 9, 2);
    check("rs_e7", got(), pack(9, 0, 0, 1, 0));
    run_idle("rs_after", 2);
    check("rs_e9", got(), pack(4, 1, 1, 1, 0));

    // reset mid-run overrides start
    cyc("rst_start", 1, 1, 0, 12, 3);
    run_idle("rst_run", 3);
    cyc("rst_e4", 0, 1, 1, 7, 1);
    check("rst_clear", got(), pack(0, 0, 0, 0, 0));
    cyc("rst_e5", 0, 1, 0, 7, 1);
    check("rst_start_ignored", got(), pack(0, 0, 0, 0, 0));

    // init 0 runs one period then finishes with a single halving
    cyc("z_start", 1, 1, 0, 0, 2);
    check("z_e0", got(), pack(0, 0, 0, 1, 0));
    cyc("z_e1", 1, 0, 0, 0, 0);
    cyc("z_e2", 1, 0, 0, 0, 0);
    check("z_done", got(), pack(0, 1, 1, 0, 1));
    cyc("z_e3", 1, 0, 0, 0, 0);
    check("z_single_tick", got(), pack(0, 1, 0, 0, 1));

    for (int i = 0; i < 3000; i++)
      cyc("random", $urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) == 0, N'($urandom), P'($urandom_range(0, 4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
